mem_arbiter: RTL and testbench

Two-port arbiter and burst sequencer that shares the single four-banked main memory between the instruction-cache controller (port I) and the data-cache controller (port D). It grants the memory to one cache at a time for a full 4-word line transfer, generates the per-beat word address, holds issue while the target bank is busy or memory stalls, and returns per-beat read-valid strobes plus an end-of-burst pulse. It sits between the two cache controllers and the memory.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_rd_pipe.sv | 45 ++++
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port main-memory arbiter: FSM states, port IDs
// and burst geometry (4 beats per line, one beat per memory bank).
package mem_arbiter_pkg;

  localparam int BEATS  = 4;
  localparam int BEAT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  function automatic logic last_beat(input logic [BEAT_W-1:0] beat);
    return beat == BEAT_W'(BEATS - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_rd_pipe.sv
// Fixed-latency tracker for read beats: carries {valid, port, beat} for RD_LAT
// cycles so read-valid strobes line up with data leaving the memory.
module arb_rd_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  port_e             port_i,
  input  logic [BEAT_W-1:0] beat_i,
  output logic              vld_o,
  output port_e             port_o,
  output logic [BEAT_W-1:0] beat_o
);

  logic [RD_LAT-1:0] vld_q;
  port_e             port_q [RD_LAT];
  logic [BEAT_W-1:0] beat_q [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= push_i;
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Tag payload is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    port_q[0] <= port_i;
    beat_q[0] <= beat_i;
    for (int i = 1; i < RD_LAT; i++) begin
      port_q[i] <= port_q[i-1];
      beat_q[i] <= beat_q[i-1];
    end
  end

  assign vld_o  = vld_q[RD_LAT-1];
  assign port_o = port_q[RD_LAT-1];
  assign beat_o = beat_q[RD_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter and 4-beat burst sequencer for the banked
// main memory. Define ARB_DCACHE_PRIO_EN for fixed D-priority instead of round-robin.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int AW     = 16,
  parameter int DW     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [AW-1:0]     i_addr,
  input  logic [DW-1:0]     i_wdata,
  output logic              i_gnt,
  output logic [BEAT_W-1:0] i_beat,
  output logic              i_rvalid,
  output logic [BEAT_W-1:0] i_rbeat,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [AW-1:0]     d_addr,
  input  logic [DW-1:0]     d_wdata,
  output logic              d_gnt,
  output logic [BEAT_W-1:0] d_beat,
  output logic              d_rvalid,
  output logic [BEAT_W-1:0] d_rbeat,
  output logic              d_done,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_data_in,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic              mem_stall,
  input  logic [3:0]        mem_busy
);

  state_e            state_q, state_d;
  port_e             owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [AW-1:0]     line_q;
  port_e             pick;
  logic              grant_load;
  logic              accept;
  logic              done;
  logic              busy_st;
  logic              pipe_vld;
  port_e             pipe_port;
  logic [BEAT_W-1:0] pipe_beat;

`ifdef ARB_DCACHE_PRIO_EN
  always_comb begin
    pick = d_req ? PORT_D : PORT_I;
  end
`else
  port_e last_q;

  // On a tie, favour whichever port did not win the previous grant.
  always_comb begin
    pick = PORT_I;
    if (i_req && d_req) pick = (last_q == PORT_I) ? PORT_D : PORT_I;
    else if (d_req)     pick = PORT_D;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             last_q <= PORT_I;
    else if (grant_load) last_q <= pick;
  end
`endif

  assign busy_st = (state_q == ST_BURST);
  assign accept  = busy_st && !mem_stall && !mem_busy[beat_q];

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    beat_d     = beat_q;
    grant_load = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          grant_load = 1'b1;
          owner_d    = pick;
          wr_d       = (pick == PORT_D) ? d_wr : i_wr;
          beat_d     = '0;
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        if (accept) begin
          beat_d = beat_q + 1'b1;
          if (last_beat(beat_q)) begin
            if (wr_q) begin
              done    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (pipe_vld && last_beat(pipe_beat)) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= PORT_I;
      wr_q    <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      beat_q  <= beat_d;
    end
  end

  // Line address is captured at grant so a withdrawn request cannot corrupt the burst.
  always_ff @(posedge clk) begin
    if (grant_load) line_q <= ((pick == PORT_D) ? d_addr : i_addr) & ~AW'(7);
  end

  arb_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk    (clk),
    .rst    (rst),
    .push_i (accept && !wr_q),
    .port_i (owner_q),
    .beat_i (beat_q),
    .vld_o  (pipe_vld),
    .port_o (pipe_port),
    .beat_o (pipe_beat)
  );

  assign i_gnt    = (state_q != ST_IDLE) && (owner_q == PORT_I);
  assign d_gnt    = (state_q != ST_IDLE) && (owner_q == PORT_D);
  assign i_beat   = i_gnt ? beat_q : '0;
  assign d_beat   = d_gnt ? beat_q : '0;
  assign i_done   = done && (owner_q == PORT_I);
  assign d_done   = done && (owner_q == PORT_D);
  assign i_rvalid = pipe_vld && (pipe_port == PORT_I);
  assign d_rvalid = pipe_vld && (pipe_port == PORT_D);
  assign i_rbeat  = i_rvalid ? pipe_beat : '0;
  assign d_rbeat  = d_rvalid ? pipe_beat : '0;

  assign mem_rd      = accept && !wr_q;
  assign mem_wr      = accept && wr_q;
  assign mem_addr    = busy_st ? (line_q | {{(AW-3){1'b0}}, beat_q, 1'b0}) : '0;
  assign mem_data_in = busy_st ? ((owner_q == PORT_D) ? d_wdata : i_wdata) : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: logs memory/strobe activity per cycle and checks
// it against hand-derived cycle numbers relative to each request.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic i_req, i_wr, d_req, d_wr;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata;
  logic i_gnt, d_gnt, i_rvalid, d_rvalid, i_done, d_done;
  logic [1:0] i_beat, d_beat, i_rbeat, d_rbeat;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic mem_wr, mem_rd, mem_stall;
  logic [3:0] mem_busy;

  always #5 clk = ~clk;

  mem_arbiter #(.RD_LAT(RD_LAT), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_gnt(i_gnt), .i_beat(i_beat), .i_rvalid(i_rvalid), .i_rbeat(i_rbeat), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_beat(d_beat), .d_rvalid(d_rvalid), .d_rbeat(d_rbeat), .d_done(d_done),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_stall(mem_stall), .mem_busy(mem_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle activity log, sampled on the falling edge.
  int mcyc = 0;
  int viol = 0;
  int acc_addr[$], acc_cyc[$], acc_wr[$], acc_data[$];
  int irv_b[$], irv_c[$], drv_b[$], drv_c[$];
  int idone_c[$], ddone_c[$], igr_c[$], dgr_c[$];
  logic igp = 1'b0, dgp = 1'b0;

  always @(negedge clk) begin
    if (mem_rd || mem_wr) begin
      acc_addr.push_back(int'(mem_addr));
      acc_cyc.push_back(mcyc);
      acc_wr.push_back(int'(mem_wr));
      acc_data.push_back(int'(mem_data_in));
    end
    if (mem_rd && mem_wr) viol++;
    if (i_gnt && d_gnt) viol++;
    if (i_rvalid) begin irv_b.push_back(int'(i_rbeat)); irv_c.push_back(mcyc); end
    if (d_rvalid) begin drv_b.push_back(int'(d_rbeat)); drv_c.push_back(mcyc); end
    if (i_done) idone_c.push_back(mcyc);
    if (d_done) ddone_c.push_back(mcyc);
    if (i_gnt && !igp) igr_c.push_back(mcyc);
    if (d_gnt && !dgp) dgr_c.push_back(mcyc);
    igp = i_gnt;
    dgp = d_gnt;
    mcyc++;
  end

  task automatic clear_logs();
    acc_addr.delete(); acc_cyc.delete(); acc_wr.delete(); acc_data.delete();
    irv_b.delete(); irv_c.delete(); drv_b.delete(); drv_c.delete();
    idone_c.delete(); ddone_c.delete(); igr_c.delete(); dgr_c.delete();
  endtask

  function automatic int qget(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit is_d, input int budget);
    int n;
    n = 0;
    while (1) begin
      tick();
      n++;
      if (is_d ? (ddone_c.size() > 0) : (idone_c.size() > 0)) begin
        if (is_d) d_req = 1'b0; else i_req = 1'b0;
        break;
      end
      if (n >= budget) begin
        check("done_timeout", 32'd0, 32'd1);
        i_req = 1'b0;
        d_req = 1'b0;
        break;
      end
    end
  endtask

  task automatic both_round(input bit exp_d, input string tag);
    clear_logs();
    i_wr = 1'b1; d_wr = 1'b1; i_addr = 16'h0600; d_addr = 16'h0700;
    i_req = 1'b1; d_req = 1'b1;
    tick();
    check({tag, "_dgnt"}, d_gnt, exp_d);
    check({tag, "_ignt"}, i_gnt, !exp_d);
    if (exp_d) i_req = 1'b0; else d_req = 1'b0;
    wait_done(exp_d, 20);
    tick(); tick();
  endtask

  int t0;
  int exp_c[4];
  int exp_r[4];

  initial begin
    rst = 1'b1;
    i_req = 0; i_wr = 0; i_addr = '0; i_wdata = '0;
    d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
    mem_stall = 0; mem_busy = '0;
    #12;
    check("rst_ignt", i_gnt, 0);
    check("rst_dgnt", d_gnt, 0);
    check("rst_memrd", mem_rd, 0);
    check("rst_memwr", mem_wr, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_done", {i_done, d_done}, 0);
    @(negedge clk);
    rst = 1'b0;

    // I read from 0x0040, no stalls
    tick();
    clear_logs();
    t0 = mcyc;
    i_req = 1'b1; i_wr = 1'b0; i_addr = 16'h0040;
    wait_done(1'b0, 20);
    tick(); tick();
    check("rd_nacc", acc_addr.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check("rd_addr", qget(acc_addr, k), 32'h40 + 2 * k);
      check("rd_acc_cyc", qget(acc_cyc, k) - t0, 1 + k);
      check("rd_acc_wr", qget(acc_wr, k), 0);
      check("rd_rbeat", qget(irv_b, k), k);
      check("rd_rv_cyc", qget(irv_c, k) - t0, 3 + k);
    end
    check("rd_nrv", irv_b.size(), 4);
    check("rd_ndone", idone_c.size(), 1);
    check("rd_done_cyc", qget(idone_c, 0) - t0, 6);
    check("rd_gnt_cyc", qget(igr_c, 0) - t0, 1);

    // Two simultaneous-request rounds
`ifdef ARB_DCACHE_PRIO_EN
    both_round(1'b1, "tie1");
    both_round(1'b1, "tie2");
`else
    both_round(1'b1, "tie1");
    both_round(1'b0, "tie2");
`endif

    // D write to 0x1000 with bank 2 busy for three cycles
    clear_logs();
    t0 = mcyc;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h1000; d_wdata = '0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      mem_busy = (c >= 3 && c <= 5) ? 4'b0100 : 4'b0000;
      d_wdata = 16'hA000 + 16'(d_beat);
      if (ddone_c.size() > 0) d_req = 1'b0;
    end
    mem_busy = '0;
    exp_c = '{1, 2, 6, 7};
    check("wr_nacc", acc_addr.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check("wr_addr", qget(acc_addr, k), 32'h1000 + 2 * k);
      check("wr_cyc", qget(acc_cyc, k) - t0, exp_c[k]);
      check("wr_flag", qget(acc_wr, k), 1);
      check("wr_data", qget(acc_data, k), 32'hA000 + k);
    end
    check("wr_ndone", ddone_c.size(), 1);
    check("wr_done_cyc", qget(ddone_c, 0) - t0, 7);
    check("wr_no_rv", drv_b.size(), 0);

    // I read 0x0100 with mem_stall toggling
    clear_logs();
    t0 = mcyc;
    i_req = 1'b1; i_wr = 1'b0; i_addr = 16'h0100;
    for (int c = 1; c <= 16; c++) begin
      tick();
      mem_stall = (c % 2 == 1);
      if (idone_c.size() > 0) i_req = 1'b0;
    end
    mem_stall = 1'b0;
    exp_c = '{2, 4, 6, 8};
    exp_r = '{4, 6, 8, 10};
    check("st_nacc", acc_addr.size(), 4);
    check("st_nrv", irv_b.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check("st_addr", qget(acc_addr, k), 32'h100 + 2 * k);
      check("st_acc_cyc", qget(acc_cyc, k) - t0, exp_c[k]);
      check("st_rbeat", qget(irv_b, k), k);
      check("st_rv_cyc", qget(irv_c, k) - t0, exp_r[k]);
    end
    check("st_done_cyc", qget(idone_c, 0) - t0, 10);

    // Reset during beat 1 of a D read
    clear_logs();
    t0 = mcyc;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h2000;
    tick();
    tick();
    check("rr_beat_pre", d_beat, 1);
    rst = 1'b1;
    #1;
    check("rr_dgnt", d_gnt, 0);
    check("rr_memrd", mem_rd, 0);
    check("rr_addr", mem_addr, 0);
    check("rr_dbeat", d_beat, 0);
    d_req = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    check("rr_nacc", acc_addr.size(), 1);
    check("rr_no_done", ddone_c.size(), 0);
    check("rr_no_rv", drv_b.size(), 0);

    clear_logs();
    t0 = mcyc;
    i_req = 1'b1; i_wr = 1'b1; i_addr = 16'h0300;
    wait_done(1'b0, 20);
    tick(); tick();
    check("rr_i_nacc", acc_addr.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check("rr_i_addr", qget(acc_addr, k), 32'h300 + 2 * k);
      check("rr_i_cyc", qget(acc_cyc, k) - t0, 1 + k);
    end
    check("rr_i_done", qget(idone_c, 0) - t0, 4);

    // D waits while I bursts
    clear_logs();
    t0 = mcyc;
    i_req = 1'b1; i_wr = 1'b0; i_addr = 16'h0400;
    tick();
    tick();
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0500;
    for (int c = 3; c <= 20; c++) begin
      tick();
      if (idone_c.size() > 0) i_req = 1'b0;
      if (ddone_c.size() > 0) d_req = 1'b0;
    end
    check("hold_i_done", qget(idone_c, 0) - t0, 6);
    check("hold_d_gnt", qget(dgr_c, 0) - t0, 8);
    check("hold_d_done", qget(ddone_c, 0) - t0, 11);
    check("hold_nacc", acc_addr.size(), 8);
    check("hold_d_addr", qget(acc_addr, 4), 32'h500);

    check("exclusive", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
